// File: rtl/fan_led_pkg.sv
// Shared encodings for the multi-fan status LED controller.
// Mode values, LED pin codes and hold counter width.
package fan_led_pkg;

  localparam int HOLD_W = 4;

  typedef enum logic [2:0] {
    FLM_AUTO   = 3'b000,
    FLM_OFF    = 3'b001,
    FLM_GREEN  = 3'b010,
    FLM_RED    = 3'b011,
    FLM_GBLINK = 3'b100,
    FLM_RBLINK = 3'b101
  } flm_e;

  // {FanOK, FanFail}, both active-low
  typedef logic [1:0] led_t;
  localparam led_t LED_OFF   = 2'b11;
  localparam led_t LED_GREEN = 2'b01;
  localparam led_t LED_RED   = 2'b10;

endpackage

// File: rtl/fan_fail_hold.sv
// Per-fan Beep synchroniser, masked fail hold counter
// and sticky fail flag.
module fan_fail_hold
  import fan_led_pkg::*;
#(
  parameter int HOLD_TICKS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  input  logic beep,
  input  logic mask,
  input  logic clr,
  output logic fail,
  output logic sticky
);

  logic [1:0]        sync;
  logic [HOLD_W-1:0] cnt;
  logic              tone;

  assign tone = sync[1];
  assign fail = (cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync   <= '0;
      cnt    <= '0;
      sticky <= 1'b0;
    end else begin
      sync <= {sync[0], beep};
      if (mask)
        cnt <= '0;
      else if (tone)
        cnt <= HOLD_W'(HOLD_TICKS);
      else if (strobe && cnt != '0)
        cnt <= cnt - HOLD_W'(1);
      // a rising fail beats a simultaneous clear
      sticky <= fail | (sticky & ~clr);
    end
  end

endmodule

// File: rtl/fan_led_multi.sv
// Multi-fan status LED: per-fan fail hold, fail count,
// blink generator and registered bicolour LED decode.
module fan_led_multi
  import fan_led_pkg::*;
#(
  parameter int NUM_FANS    = 4,
  parameter int HOLD_TICKS  = 3,
  parameter int FAIL_THRESH = 2,
  parameter int BLINK_TICKS = 16
) (
  input  logic                SlowClock,
  input  logic                Reset,
  input  logic                Strobe16ms,
  input  logic [NUM_FANS-1:0] Beep,
  input  logic [NUM_FANS-1:0] FanMask,
  input  logic [2:0]          FanLedMode,
  input  logic [NUM_FANS-1:0] FailClr,
  output logic                FanOK,
  output logic                FanFail,
  output logic [NUM_FANS-1:0] FanFailVec,
  output logic [NUM_FANS-1:0] FanFailSticky,
  output logic                FanFailAny
);

  localparam int CW = $clog2(NUM_FANS + 1);
  localparam logic [CW-1:0] THRESH = CW'(FAIL_THRESH);

  logic [CW-1:0] fail_count;
  logic [7:0]    blink_cnt;
  logic          blink_phase;
  led_t          led_next;
  led_t          led;

  for (genvar g = 0; g < NUM_FANS; g++) begin : g_fan
    fan_fail_hold #(
      .HOLD_TICKS(HOLD_TICKS)
    ) u_hold (
      .clk   (SlowClock),
      .rst   (Reset),
      .strobe(Strobe16ms),
      .beep  (Beep[g]),
      .mask  (FanMask[g]),
      .clr   (FailClr[g]),
      .fail  (FanFailVec[g]),
      .sticky(FanFailSticky[g])
    );
  end

  assign FanFailAny = |FanFailVec;

  always_comb begin
    fail_count = '0;
    for (int i = 0; i < NUM_FANS; i++)
      fail_count = fail_count + CW'(FanFailVec[i]);
  end

  always_ff @(posedge SlowClock or posedge Reset) begin
    if (Reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (Strobe16ms) begin
      if (blink_cnt == 8'(BLINK_TICKS - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    led_next = LED_OFF;
    case (FanLedMode)
      FLM_AUTO: begin
        if (fail_count == '0)
          led_next = LED_GREEN;
        else if (fail_count < THRESH)
          led_next = blink_phase ? LED_RED : LED_OFF;
        else
          led_next = LED_RED;
      end
      FLM_OFF:    led_next = LED_OFF;
      FLM_GREEN:  led_next = LED_GREEN;
      FLM_RED:    led_next = LED_RED;
      FLM_GBLINK: led_next = blink_phase ? LED_GREEN : LED_OFF;
      FLM_RBLINK: led_next = blink_phase ? LED_RED : LED_OFF;
      default:    led_next = LED_OFF;
    endcase
  end

  always_ff @(posedge SlowClock or posedge Reset) begin
    if (Reset)
      led <= LED_OFF;
    else
      led <= led_next;
  end

  assign {FanOK, FanFail} = led;

endmodule

// File: tb/tb_fan_led_multi.sv
// Randomised and directed bench for fan_led_multi with
// a time-based reference model of hold, blink and LED.
module tb_fan_led_multi;

  localparam int N    = 4;
  localparam int HOLD = 3;
  localparam int THR  = 2;
  localparam int BT   = 4;

  logic         clk;
  logic         Reset;
  logic         Strobe16ms;
  logic [N-1:0] Beep;
  logic [N-1:0] FanMask;
  logic [2:0]   FanLedMode;
  logic [N-1:0] FailClr;
  logic         FanOK;
  logic         FanFail;
  logic [N-1:0] FanFailVec;
  logic [N-1:0] FanFailSticky;
  logic         FanFailAny;

  int checks;
  int failures;
  int cyc;

  int           strobes;
  logic [N-1:0] b1;
  logic [N-1:0] b2;
  bit           alive[N];
  int           since[N];
  logic [N-1:0] m_sticky;
  logic [1:0]   m_led;

  fan_led_multi #(
    .NUM_FANS(N),
    .HOLD_TICKS(HOLD),
    .FAIL_THRESH(THR),
    .BLINK_TICKS(BT)
  ) dut (
    .SlowClock    (clk),
    .Reset        (Reset),
    .Strobe16ms   (Strobe16ms),
    .Beep         (Beep),
    .FanMask      (FanMask),
    .FanLedMode   (FanLedMode),
    .FailClr      (FailClr),
    .FanOK        (FanOK),
    .FanFail      (FanFail),
    .FanFailVec   (FanFailVec),
    .FanFailSticky(FanFailSticky),
    .FanFailAny   (FanFailAny)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] mfail();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++)
      r[i] = alive[i] && (since[i] < HOLD);
    return r;
  endfunction

  function automatic bit mphase();
    return ((strobes / BT) % 2) == 1;
  endfunction

  function automatic logic [1:0] led_ref(
    input logic [2:0] mode, input int cnt, input bit ph);
    case (mode)
      3'd0: begin
        if (cnt == 0) return 2'b01;
        else if (cnt < THR) return ph ? 2'b10 : 2'b11;
        else return 2'b10;
      end
      3'd1: return 2'b11;
      3'd2: return 2'b01;
      3'd3: return 2'b10;
      3'd4: return ph ? 2'b01 : 2'b11;
      3'd5: return ph ? 2'b10 : 2'b11;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [10:0] exp_bus();
    logic [N-1:0] f;
    f = mfail();
    return {m_led, |f, f, m_sticky};
  endfunction

  function automatic logic [10:0] obs_bus();
    return {FanOK, FanFail, FanFailAny, FanFailVec, FanFailSticky};
  endfunction

  task automatic model_reset();
    strobes  = 0;
    b1       = '0;
    b2       = '0;
    m_sticky = '0;
    m_led    = 2'b11;
    for (int i = 0; i < N; i++) begin
      alive[i] = 1'b0;
      since[i] = 0;
    end
  endtask

  task automatic strobe_tick();
    Strobe16ms = (cyc % 3 == 0);
    cyc++;
  endtask

  task automatic step();
    logic [N-1:0] f_old;
    bit ph_old;
    f_old  = mfail();
    ph_old = mphase();
    @(posedge clk);
    if (!Reset) begin
      m_led = led_ref(FanLedMode, $countones(f_old), ph_old);
      for (int i = 0; i < N; i++) begin
        m_sticky[i] = f_old[i] ? 1'b1 : (FailClr[i] ? 1'b0 : m_sticky[i]);
        if (FanMask[i])
          alive[i] = 1'b0;
        else if (b2[i]) begin
          alive[i] = 1'b1;
          since[i] = 0;
        end else if (Strobe16ms && alive[i] && since[i] < HOLD)
          since[i]++;
      end
      b2 = b1;
      b1 = Beep;
      if (Strobe16ms) strobes++;
    end
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    model_reset();
    step();
    checks++;
    if (obs_bus() !== 11'b11_0_0000_0000) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", obs_bus(), 11'b11_0_0000_0000);
    end
    Reset = 1'b0;
    step();
    checks++;
    if ({FanOK, FanFail, FanFailVec} !== 6'b01_0000) begin
      failures++;
      $display("FAIL idle_green got=%b exp=%b", {FanOK, FanFail, FanFailVec}, 6'b01_0000);
    end
  endtask

  task automatic test_single_pulse();
    int n;
    int k;
    Beep = 4'b0010;
    strobe_tick();
    step();
    Beep = '0;
    strobe_tick();
    step();
    checks++;
    if (FanFailVec[1] !== 1'b0) begin
      failures++;
      $display("FAIL pulse_early got=%b exp=0", FanFailVec[1]);
    end
    strobe_tick();
    step();
    checks++;
    if (FanFailVec[1] !== 1'b1) begin
      failures++;
      $display("FAIL pulse_rise got=%b exp=1", FanFailVec[1]);
    end
    n = 0;
    k = 0;
    while (FanFailVec[1] === 1'b1 && k < 60) begin
      strobe_tick();
      if (Strobe16ms) n++;
      step();
      k++;
      checks++;
      if (obs_bus() !== exp_bus()) begin
        failures++;
        $display("FAIL pulse_hold t=%0t got=%b exp=%b", $time, obs_bus(), exp_bus());
      end
    end
    checks++;
    if (n != HOLD || FanFailVec[1] !== 1'b0) begin
      failures++;
      $display("FAIL hold_strobes got=%0d exp=%0d", n, HOLD);
    end
    for (int j = 0; j < 20; j++) begin
      strobe_tick();
      step();
      checks++;
      if (obs_bus() !== exp_bus()) begin
        failures++;
        $display("FAIL pulse_after t=%0t got=%b exp=%b", $time, obs_bus(), exp_bus());
      end
    end
    checks++;
    if (FanFailSticky[1] !== 1'b1) begin
      failures++;
      $display("FAIL sticky_kept got=%b exp=1", FanFailSticky[1]);
    end
    FailClr = 4'b0010;
    step();
    FailClr = '0;
    checks++;
    if (FanFailSticky[1] !== 1'b0) begin
      failures++;
      $display("FAIL sticky_clr got=%b exp=0", FanFailSticky[1]);
    end
  endtask

  task automatic test_threshold_mask();
    Beep = 4'b0101;
    for (int j = 0; j < 6; j++) begin
      strobe_tick();
      step();
      checks++;
      if (obs_bus() !== exp_bus()) begin
        failures++;
        $display("FAIL thresh_run t=%0t got=%b exp=%b", $time, obs_bus(), exp_bus());
      end
    end
    checks++;
    if ({FanOK, FanFail} !== 2'b10) begin
      failures++;
      $display("FAIL solid_red got=%b exp=10", {FanOK, FanFail});
    end
    FanMask = 4'b0100;
    for (int j = 0; j < 2; j++) begin
      strobe_tick();
      step();
      checks++;
      if (obs_bus() !== exp_bus()) begin
        failures++;
        $display("FAIL mask_run t=%0t got=%b exp=%b", $time, obs_bus(), exp_bus());
      end
    end
    checks++;
    if (FanFailVec !== 4'b0001 || FanOK !== 1'b1) begin
      failures++;
      $display("FAIL mask_blink got=%b/%b exp=0001/1", FanFailVec, FanOK);
    end
    FanMask = '0;
    Beep    = '0;
    for (int j = 0; j < 20; j++) begin
      strobe_tick();
      step();
    end
    FailClr = 4'b1111;
    step();
    FailClr = '0;
    checks++;
    if (obs_bus() !== exp_bus() || FanFailSticky !== 4'b0000) begin
      failures++;
      $display("FAIL thresh_clear got=%b exp=%b", obs_bus(), exp_bus());
    end
  endtask

  task automatic test_sticky_race();
    Beep = 4'b1000;
    step();
    Beep = '0;
    step();
    step();
    checks++;
    if (FanFailVec[3] !== 1'b1 || FanFailSticky[3] !== 1'b0) begin
      failures++;
      $display("FAIL race_rise got=%b/%b exp=1/0", FanFailVec[3], FanFailSticky[3]);
    end
    FailClr = 4'b1000;
    step();
    FailClr = '0;
    checks++;
    if (FanFailSticky[3] !== 1'b1) begin
      failures++;
      $display("FAIL race_set_wins got=%b exp=1", FanFailSticky[3]);
    end
    for (int j = 0; j < 15; j++) begin
      strobe_tick();
      step();
    end
    FailClr = 4'b1000;
    step();
    FailClr = '0;
    checks++;
    if (obs_bus() !== exp_bus()) begin
      failures++;
      $display("FAIL race_end got=%b exp=%b", obs_bus(), exp_bus());
    end
  endtask

  task automatic test_mode_sweep();
    logic [2:0] modes[7];
    modes = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    Beep = 4'b0001;
    for (int j = 0; j < 5; j++) begin
      strobe_tick();
      step();
    end
    foreach (modes[m]) begin
      FanLedMode = modes[m];
      for (int j = 0; j < 14; j++) begin
        strobe_tick();
        step();
        checks++;
        if (obs_bus() !== exp_bus() || FanFailAny !== 1'b1) begin
          failures++;
          $display("FAIL mode_%0d got=%b exp=%b", modes[m], obs_bus(), exp_bus());
        end
      end
    end
    FanLedMode = 3'd0;
  endtask

  task automatic test_async_reset();
    bit hit;
    hit  = 1'b0;
    Beep = '0;
    for (int k = 0; k < 60; k++) begin
      strobe_tick();
      step();
      if (alive[0] && since[0] == 1) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit || FanFailVec[0] !== 1'b1) begin
      failures++;
      $display("FAIL areset_setup got=%b exp=1", FanFailVec[0]);
    end
    Strobe16ms = 1'b0;
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (FanFailVec !== 4'b0000 || {FanOK, FanFail} !== 2'b11) begin
      failures++;
      $display("FAIL areset_async got=%b/%b exp=0000/11", FanFailVec, {FanOK, FanFail});
    end
    model_reset();
    step();
    step();
    Reset = 1'b0;
    step();
    checks++;
    if ({FanOK, FanFail} !== 2'b01 || obs_bus() !== exp_bus()) begin
      failures++;
      $display("FAIL areset_release got=%b exp=%b", obs_bus(), exp_bus());
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 400; j++) begin
      for (int i = 0; i < N; i++)
        Beep[i] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) FanMask = 4'($urandom);
      FailClr = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 59) == 0) FanLedMode = 3'($urandom);
      Strobe16ms = ($urandom_range(0, 2) == 0);
      step();
      checks++;
      if (obs_bus() !== exp_bus()) begin
        failures++;
        $display("FAIL random t=%0t got=%b exp=%b", $time, obs_bus(), exp_bus());
      end
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    Reset      = 1'b1;
    Strobe16ms = 1'b0;
    Beep       = '0;
    FanMask    = '0;
    FanLedMode = 3'd0;
    FailClr    = '0;
    model_reset();
    test_reset();
    test_single_pulse();
    test_threshold_mask();
    test_sticky_race();
    test_mode_sweep();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
